// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, funct codes, FSM states and ALU ops for mc_core
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_RESETX,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

endpackage

// File: rtl/mc_core_if.sv
// rtl/mc_core_if.sv - memory request/response bus between mc_core and memory
interface mc_core_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - register file, two async read ports, one sync write port, r0 hardwired to zero
module mc_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_ra_a,
  output logic [DATA_W-1:0] o_rd_a,
  input  logic [AW-1:0]     i_ra_b,
  output logic [DATA_W-1:0] o_rd_b,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd
);
  logic [DATA_W-1:0] r_regs [NREGS];

  // clear everything on reset; otherwise write one register, never r0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd_a = (i_ra_a == '0) ? '0 : r_regs[i_ra_a];
  assign o_rd_b = (i_ra_b == '0) ? '0 : r_regs[i_ra_b];
endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multicycle MIPS-subset core with registered memory request outputs
module mc_core
  import mc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                NREGS    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_core_if.master         bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  localparam int RA_W = $clog2(NREGS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_halted;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_dst;
  logic              w_legal;
  alu_op_t           w_alu_op;
  logic [DATA_W-1:0] w_simm;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_boff;
  logic [ADDR_W-1:0] w_br_pc;
  logic [ADDR_W-1:0] w_jump;
  logic [ADDR_W-1:0] w_mem_ea;
  logic              w_wb_we;

  assign w_opcode = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_simm   = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

  // classify the latched instruction: legality, ALU operation and destination register
  always_comb begin
    w_legal  = 1'b1;
    w_alu_op = ALU_ADD;
    w_dst    = w_rt;
    case (w_opcode)
      OP_RTYPE: begin
        w_dst = w_rd;
        case (w_funct)
          FN_ADD:  w_alu_op = ALU_ADD;
          FN_SUB:  w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_SLT:  w_alu_op = ALU_SLT;
          default: w_legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: w_alu_op = ALU_ADD;
      OP_BEQ:  w_alu_op = ALU_SUB;
      default: w_legal  = 1'b0;  // halt and every unlisted opcode stop the core
    endcase
  end

  assign w_alu_b = ((w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ)) ? r_b : w_simm;

  // ALU, wrapping arithmetic, signed set-less-than
  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_res = r_a + w_alu_b;
      ALU_SUB: w_alu_res = r_a - w_alu_b;
      ALU_AND: w_alu_res = r_a & w_alu_b;
      ALU_OR:  w_alu_res = r_a | w_alu_b;
      ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_res = '0;
    endcase
  end

  // PC arithmetic wraps naturally at ADDR_W; branch offset is sign-extended word offset
  assign w_pc4    = r_pc + ADDR_W'(4);
  assign w_boff   = {{(ADDR_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_br_pc  = (r_a == r_b) ? (r_pc + w_boff) : r_pc;
  assign w_jump   = (r_pc & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({r_ir[25:0], 2'b00});
  assign w_mem_ea = ADDR_W'(w_alu_res);
  assign w_wb_we  = (r_state == ST_WB);

  mc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ra_a  (w_rs[RA_W-1:0]),
    .o_rd_a  (w_rd_a),
    .i_ra_b  (w_rt[RA_W-1:0]),
    .o_rd_b  (w_rd_b),
    .i_we    (w_wb_we),
    .i_wa    (w_dst[RA_W-1:0]),
    .i_wd    (r_result)
  );

  // main FSM; memory request outputs are set on the edge that enters FETCH or MEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RESETX;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_RESETX: begin
          r_state    <= ST_FETCH;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
        end
        ST_FETCH: begin
          if (bus.mem_ack) begin
            r_ir      <= bus.mem_rdata[31:0];
            r_pc      <= w_pc4;
            r_mem_req <= 1'b0;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_a <= w_rd_a;
          r_b <= w_rd_b;
          if (!w_legal) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (w_opcode == OP_J) begin
            r_pc       <= w_jump;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_jump;
            r_state    <= ST_FETCH;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_alu_res;
          if (w_opcode == OP_BEQ) begin
            r_pc       <= w_br_pc;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_br_pc;
            r_state    <= ST_FETCH;
          end else if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_opcode == OP_SW);
            r_mem_addr  <= w_mem_ea;
            r_mem_wdata <= r_b;
            r_state     <= ST_MEM;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (bus.mem_ack) begin
            if (w_opcode == OP_LW) begin
              r_result  <= bus.mem_rdata;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_state   <= ST_WB;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
          r_state    <= ST_FETCH;
        end
        ST_HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
          r_state   <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign pc            = r_pc;
  assign halted        = r_halted;
endmodule
